// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: exposes the raster coordinate to the pixel pipeline and
// realigns sync/blank with the returned colour before registering everything onto the pins.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned PIX_LATENCY = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   output logic [9:0] vga_drawx,
   output logic [9:0] vga_drawy,
   input  logic [7:0] vga_r_in,
   input  logic [7:0] vga_g_in,
   input  logic [7:0] vga_b_in,
   output logic       frame_start,
   output logic       line_start,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       VGA_CLK
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
   localparam logic [9:0] HActive    = 10'(H_ACTIVE);
   localparam logic [9:0] VActive    = 10'(V_ACTIVE);
   localparam logic [9:0] HSyncFirst = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HSyncLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VSyncFirst = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VSyncLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;

   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_q == HLast) begin
         hc_d = '0;
         vc_d = (vc_q == VLast) ? '0 : vc_q + 10'd1;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign vga_drawx   = hc_q;
   assign vga_drawy   = vc_q;
   assign line_start  = (hc_q == '0);
   assign frame_start = (hc_q == '0) && (vc_q == '0);

   // {active, hs_n, vs_n} for the coordinate currently on drawx/drawy
   logic [2:0] pix_now;
   logic [2:0] pix_dly;

   always_comb begin
      pix_now[2] = (hc_q < HActive) && (vc_q < VActive);
      pix_now[1] = !((hc_q >= HSyncFirst) && (hc_q <= HSyncLast));
      pix_now[0] = !((vc_q >= VSyncFirst) && (vc_q <= VSyncLast));
   end

   generate
      if (PIX_LATENCY == 0) begin : g_no_dly
         assign pix_dly = pix_now;
      end else begin : g_dly
         logic [2:0] dly_q [PIX_LATENCY];

         always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
               for (int i = 0; i < PIX_LATENCY; i++) dly_q[i] <= 3'b011;
            end else begin
               dly_q[0] <= pix_now;
               for (int i = 1; i < PIX_LATENCY; i++) dly_q[i] <= dly_q[i-1];
            end
         end

         assign pix_dly = dly_q[PIX_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else begin
         // Colour is forced black outside the visible area so the system need not range-check
         VGA_R       <= pix_dly[2] ? vga_r_in : 8'h00;
         VGA_G       <= pix_dly[2] ? vga_g_in : 8'h00;
         VGA_B       <= pix_dly[2] ? vga_b_in : 8'h00;
         VGA_HS      <= pix_dly[1];
         VGA_VS      <= pix_dly[0];
         VGA_BLANK_N <= pix_dly[2];
      end
   end

   assign VGA_SYNC_N = 1'b0;
   // DAC latches on the rising edge of this, i.e. mid-cycle of the pixel clock
   assign VGA_CLK    = ~clk_clk;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 at 60 Hz VGA raster timing from the 25 MHz pixel clock (`nios2_pll_vga_clk`). It presents the current raster coordinate to the system as `vga_drawx`/`vga_drawy` and takes back the system's `vga_r`/`g`/`b` colour for that coordinate. It then delays the sync and blank decode to match the system's pixel-pipeline latency, and registers the aligned colour, syncs and blank onto the DAC/connector pins. It also emits per-frame and per-line strobes for buffer swapping.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch (H_TOTAL = 800)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch (V_TOTAL = 525)
- `PIX_LATENCY`, 2: cycles from coordinate to colour valid; legal range 0..7

Ports:
- `clk_clk` in 1: 25 MHz pixel clock
- `reset_reset_n` in 1: asynchronous, active-low reset
- `vga_drawx` out 10: raw horizontal count, 0..799
- `vga_drawy` out 10: raw vertical count, 0..524
- `vga_r_in`, `vga_g_in`, `vga_b_in` in 8 each: system colour for the coordinate issued PIX_LATENCY cycles earlier
- `frame_start` out 1: one-cycle pulse while drawx=0 and drawy=0
- `line_start` out 1: one-cycle pulse while drawx=0
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: registered pixel colour
- `VGA_HS`, `VGA_VS` out 1: registered syncs, active-low
- `VGA_BLANK_N` out 1: registered, high in active area
- `VGA_SYNC_N` out 1: constant 0
- `VGA_CLK` out 1: ~clk_clk, so the DAC latches mid-cycle

## Operation
- Counters `hc` (0..H_TOTAL-1) and `vc` (0..V_TOTAL-1); `vga_drawx`=hc and `vga_drawy`=vc, both direct register outputs.
- hc increments every cycle. At H_TOTAL-1 it wraps to 0 and vc increments. When vc is at V_TOTAL-1 on the same wrap, vc also wraps to 0.
- Decode from (hc, vc):
  - active = hc<H_ACTIVE and vc<V_ACTIVE
  - hs_n = 0 iff hc in [656,751]
  - vs_n = 0 iff vc in [490,491]
  - Bounds are derived from the parameters.
- Delay line: {active, hs_n, vs_n} pass through PIX_LATENCY register stages. Reset value of each stage is {0,1,1}. For PIX_LATENCY=0 there is no delay stage.
- Output register, one stage:
  - VGA_R/G/B = active_d ? *_in : 0
  - VGA_HS = hs_n_d
  - VGA_VS = vs_n_d
  - VGA_BLANK_N = active_d
- `frame_start` and `line_start` are combinational decodes of the counters. They are aligned with drawx/drawy, not with pin timing.
- Colour inputs are ignored (forced 0 on pins) whenever the delayed active flag is 0. The system needs no range check on drawx/drawy for blanking.

## Timing
- Coordinate C is held on drawx/drawy during cycle n. The matching colour must be stable on *_in during cycle n+PIX_LATENCY. Pins show the pixel for C from the edge ending cycle n+PIX_LATENCY.
- Coordinate-to-pin latency is PIX_LATENCY+1 edges. Syncs and blank share the same latency exactly, with zero skew between colour and sync.
- Reset (asynchronous assert, any time, including mid-line or mid-sync):
  - hc=0, vc=0
  - RGB=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0
  - delay line cleared
  - frame_start=1 and line_start=1, since they decode (0,0)
- First edge after release advances hc to 1. Pins show pixel (0,0) PIX_LATENCY+1 edges after release.
- Frame period: 800×525 = 420000 cycles.
  - HS low for 96 cycles per line.
  - VS low for 2×800 = 1600 cycles per frame.
- Simultaneous hc and vc wrap at (799,524) → (0,0) in one edge; frame_start asserts for that single cycle.

## Test plan
- Reset check: hold reset_reset_n=0 and toggle the clock. Require RGB=0, HS=VS=1, BLANK_N=0, drawx=drawy=0. Release, then require drawx=1 after the first edge.
- Horizontal timing: measure one line. Require HS low for exactly 96 cycles. HS must fall 656+PIX_LATENCY+1 edges after drawx=0, and the line period must be 800.
- Vertical timing and wrap: run a full frame. Require VS low for 1600 cycles starting at line 490. Require (799,524) → (0,0) with frame_start pulsed once per 420000 cycles.
- Latency alignment with PIX_LATENCY=2: drive colour inputs from drawx[7:0] delayed two cycles. Require VGA_R = drawx[7:0] of the coordinate 3 edges earlier, for every active pixel.
- Blanking: drive *_in = 8'hFF constantly. Require RGB=0 and BLANK_N=0 for hc≥640 or vc≥480. Require 8'hFF with BLANK_N=1 inside the active area.
- Reset mid-sync: assert reset at hc=700, vc=491. Require immediate HS=VS=1, RGB=0 and counters at 0. After release, the next HS fall must arrive exactly 656+PIX_LATENCY+1 edges later.
